local_ni22: RTL and testbench

//  Local network interface for a 2x2-mesh router node. Sits between the processing element and the router's L port.

---
 rtl/local_ni22.sv | 132 +++++++++++++
 tb/tb_local_ni22.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/local_ni22.sv
// Local network interface for one 2x2-mesh node: builds and paces injected flits into the
// router L port, and sinks, checks and time-stamps flits ejected from it for the PE.
module local_ni22 #(
  parameter int DATASIZE  = 40,
  parameter int NODE_ID   = 0,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pe_tx_valid,
  output logic                pe_tx_ready,
  input  logic [3:0]          pe_tx_dst,
  input  logic [21:0]         pe_tx_data,
  input  logic [1:0]          pe_tx_type,
  output logic [DATASIZE-1:0] rtr_data_out,
  output logic                rtr_valid_out,
  input  logic                rtr_full_in,
  input  logic [DATASIZE-1:0] rtr_data_in,
  input  logic                rtr_valid_in,
  output logic                pe_rx_valid,
  input  logic                pe_rx_ready,
  output logic [3:0]          pe_rx_src,
  output logic [21:0]         pe_rx_data,
  output logic [1:0]          pe_rx_type,
  output logic [7:0]          pe_rx_latency,
  output logic                misroute,
  output logic [CNT_W-1:0]    tx_count,
  output logic [CNT_W-1:0]    rx_count,
  output logic [CNT_W-1:0]    drop_count
);

  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);
  localparam logic [3:0] ID = 4'(NODE_ID);

  typedef enum logic [1:0] {IDLE, SEND, STALL} inj_state_t;

  logic [7:0]   ts_now;
  logic [27:0]  inj_mem [INJ_DEPTH];
  logic [IAW:0] inj_wr, inj_rd;
  logic         inj_empty, inj_full, inj_push, inj_pop;
  logic [27:0]  inj_head;
  inj_state_t   inj_state;

  logic [35:0]  ej_mem [EJ_DEPTH];
  logic [EAW:0] ej_wr, ej_rd;
  logic         ej_empty, ej_full, ej_push, ej_pop, ej_drop, dst_ok;
  logic [35:0]  ej_head;
  logic [7:0]   latency;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_now <= '0;
    else     ts_now <= ts_now + 8'd1;
  end

  // Inject queue
  assign inj_empty   = (inj_wr == inj_rd);
  assign inj_full    = (inj_wr[IAW] != inj_rd[IAW]) && (inj_wr[IAW-1:0] == inj_rd[IAW-1:0]);
  assign pe_tx_ready = !inj_full;
  assign inj_push    = pe_tx_valid && pe_tx_ready;
  assign inj_head    = inj_mem[inj_rd[IAW-1:0]];

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wr[IAW-1:0]] <= {pe_tx_dst, pe_tx_data, pe_tx_type};
  end

  // State is decoded from current occupancy and full flag so a pop sees the flag at its own edge
  always_comb begin
    inj_state = IDLE;
    inj_pop   = 1'b0;
    if (!inj_empty) inj_state = rtr_full_in ? STALL : SEND;
    if (inj_state == SEND) inj_pop = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_wr        <= '0;
      inj_rd        <= '0;
      rtr_valid_out <= 1'b0;
      rtr_data_out  <= '0;
      tx_count      <= '0;
    end else begin
      rtr_valid_out <= inj_pop;
      if (inj_push) inj_wr <= inj_wr + 1'b1;
      if (inj_pop) begin
        inj_rd       <= inj_rd + 1'b1;
        rtr_data_out <= DATASIZE'({ID, inj_head[27:24], ts_now, inj_head[23:0]});
        if (tx_count != '1) tx_count <= tx_count + CNT_W'(1);
      end
    end
  end

  // Eject queue (first-word fall-through; head outputs read 0 while empty)
  assign ej_empty = (ej_wr == ej_rd);
  assign ej_full  = (ej_wr[EAW] != ej_rd[EAW]) && (ej_wr[EAW-1:0] == ej_rd[EAW-1:0]);
  assign ej_pop   = !ej_empty && pe_rx_ready;
  assign dst_ok   = (rtr_data_in[35:32] == ID);
  assign ej_push  = rtr_valid_in && dst_ok && (!ej_full || ej_pop);
  assign ej_drop  = rtr_valid_in && !ej_push;
  assign latency  = ts_now - rtr_data_in[31:24];
  assign ej_head  = ej_empty ? '0 : ej_mem[ej_rd[EAW-1:0]];

  assign pe_rx_valid   = !ej_empty;
  assign pe_rx_src     = ej_head[35:32];
  assign pe_rx_data    = ej_head[31:10];
  assign pe_rx_type    = ej_head[9:8];
  assign pe_rx_latency = ej_head[7:0];

  always_ff @(posedge clk) begin
    if (ej_push)
      ej_mem[ej_wr[EAW-1:0]] <= {rtr_data_in[39:36], rtr_data_in[23:2], rtr_data_in[1:0], latency};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ej_wr      <= '0;
      ej_rd      <= '0;
      misroute   <= 1'b0;
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (ej_push) ej_wr <= ej_wr + 1'b1;
      if (ej_pop)  ej_rd <= ej_rd + 1'b1;
      if (rtr_valid_in && !dst_ok) misroute <= 1'b1;
      if (ej_push && rx_count != '1)   rx_count   <= rx_count + CNT_W'(1);
      if (ej_drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_local_ni22.sv
// Directed bench for local_ni22 (NODE_ID=3): expected flits are queued by the stimulus and
// checked by monitors whenever the DUT presents a flit to the router or a popped head to the PE.
module tb_local_ni22;
  localparam logic [3:0] ME = 4'd3;

  logic        clk, rst;
  logic        pe_tx_valid, pe_tx_ready;
  logic [3:0]  pe_tx_dst;
  logic [21:0] pe_tx_data;
  logic [1:0]  pe_tx_type;
  logic [39:0] rtr_data_out, rtr_data_in;
  logic        rtr_valid_out, rtr_full_in, rtr_valid_in;
  logic        pe_rx_valid, pe_rx_ready;
  logic [3:0]  pe_rx_src;
  logic [21:0] pe_rx_data;
  logic [1:0]  pe_rx_type;
  logic [7:0]  pe_rx_latency;
  logic        misroute;
  logic [15:0] tx_count, rx_count, drop_count;

  local_ni22 #(.DATASIZE(40), .NODE_ID(3), .INJ_DEPTH(4), .EJ_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready), .pe_tx_dst(pe_tx_dst),
    .pe_tx_data(pe_tx_data), .pe_tx_type(pe_tx_type),
    .rtr_data_out(rtr_data_out), .rtr_valid_out(rtr_valid_out), .rtr_full_in(rtr_full_in),
    .rtr_data_in(rtr_data_in), .rtr_valid_in(rtr_valid_in),
    .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready), .pe_rx_src(pe_rx_src),
    .pe_rx_data(pe_rx_data), .pe_rx_type(pe_rx_type), .pe_rx_latency(pe_rx_latency),
    .misroute(misroute), .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: ts_now as the DUT should see it
  logic [7:0] tb_ts;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= 8'd0;
    else     tb_ts <= tb_ts + 8'd1;
  end

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_tx[$];
  logic [35:0] exp_rx[$];
  logic [39:0] et;
  logic [35:0] er;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitors: sample 1 time unit after each falling edge
  always begin
    @(negedge clk);
    #1;
    if (!rst && rtr_valid_out) begin
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got flit %0h expected none", rtr_data_out);
      end else begin
        et = exp_tx.pop_front();
        chk("tx_flit", {rtr_data_out[39:32], rtr_data_out[23:0]}, {et[39:32], et[23:0]});
        chk("tx_ts", rtr_data_out[31:24], tb_ts - 8'd1);
      end
    end
    if (!rst && pe_rx_valid && pe_rx_ready) begin
      if (exp_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got head %0h expected none", pe_rx_data);
      end else begin
        er = exp_rx.pop_front();
        chk("rx_head", {pe_rx_src, pe_rx_data, pe_rx_type, pe_rx_latency}, er);
      end
    end
  end

  task automatic send_tx(input logic [3:0] d, input logic [21:0] dat, input logic [1:0] ty,
                         input bit keep);
    pe_tx_valid = 1'b1; pe_tx_dst = d; pe_tx_data = dat; pe_tx_type = ty;
    if (keep) exp_tx.push_back({ME, d, 8'h00, dat, ty});
  endtask

  task automatic deliver(input logic [3:0] s, input logic [3:0] d, input logic [7:0] lat,
                         input logic [21:0] dat, input logic [1:0] ty, input bit keep);
    rtr_valid_in = 1'b1;
    rtr_data_in  = {s, d, tb_ts - lat, dat, ty};
    if (keep) exp_rx.push_back({s, dat, ty, lat});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pe_tx_valid = 1'b0; pe_tx_dst = '0; pe_tx_data = '0; pe_tx_type = '0;
    rtr_full_in = 1'b0; rtr_data_in = '0; rtr_valid_in = 1'b0; pe_rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", {rtr_valid_out, pe_rx_valid, misroute, rtr_data_out}, 64'h0);
    chk("rst_counts", {tx_count, rx_count, drop_count}, 64'h0);
    chk("rst_tx_ready", pe_tx_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Latency wrap: flit stamped 250 arrives when ts_now=4
    for (int i = 0; i < 20 && tb_ts != 8'd4; i++) @(negedge clk);
    rtr_valid_in = 1'b1;
    rtr_data_in  = {4'd2, ME, 8'd250, 22'h12345, 2'd1};
    exp_rx.push_back({4'd2, 22'h12345, 2'd1, 8'd10});
    @(negedge clk);
    rtr_valid_in = 1'b0;
    #1;
    chk("lat_head_valid", pe_rx_valid, 1);
    chk("lat_value", pe_rx_latency, 8'd10);
    chk("lat_rx_count", rx_count, 1);
    @(negedge clk);
    pe_rx_ready = 1'b1;
    @(negedge clk);
    pe_rx_ready = 1'b0;
    #1;
    chk("lat_popped", pe_rx_valid, 0);

    // Single inject
    @(negedge clk);
    send_tx(4'd1, 22'h2AAAA, 2'd2, 1'b1);
    #1;
    chk("t1_ready", pe_tx_ready, 1);
    @(negedge clk);
    pe_tx_valid = 1'b0;
    #1;
    chk("t1_not_yet", rtr_valid_out, 0);
    @(negedge clk);
    #1;
    chk("t1_pulse", rtr_valid_out, 1);
    @(negedge clk);
    #1;
    chk("t1_pulse_end", rtr_valid_out, 0);
    chk("t1_tx_count", tx_count, 1);

    // Fill inject queue under full, then release
    @(negedge clk);
    rtr_full_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      send_tx(4'(i), 22'h100 + 22'(i), 2'(i), 1'b1);
      #1;
      chk("t2_ready_fill", pe_tx_ready, 1);
    end
    @(negedge clk);
    pe_tx_valid = 1'b0;
    #1;
    chk("t2_ready_full", pe_tx_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_stalled", rtr_valid_out, 0);
      @(negedge clk);
      #1;
    end
    rtr_full_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("t2_burst", rtr_valid_out, 1);
    end
    @(negedge clk);
    #1;
    chk("t2_burst_end", rtr_valid_out, 0);
    chk("t2_tx_count", tx_count, 5);
    chk("t2_ready_back", pe_tx_ready, 1);

    // Overfill eject queue: 6 flits, 4 kept
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      deliver(4'(i), ME, 8'(i + 1), 22'h100 + 22'(i), 2'(i), i < 4);
    end
    @(negedge clk);
    rtr_valid_in = 1'b0;
    #1;
    chk("t4_drop", drop_count, 2);
    chk("t4_rx", rx_count, 5);
    chk("t4_head_lat", pe_rx_latency, 1);

    // Misrouted flit
    @(negedge clk);
    deliver(4'd1, 4'd2, 8'd3, 22'h3_0000, 2'd0, 1'b0);
    @(negedge clk);
    rtr_valid_in = 1'b0;
    #1;
    chk("t5_misroute", misroute, 1);
    chk("t5_drop", drop_count, 3);
    chk("t5_rx", rx_count, 5);
    chk("t5_head_same", pe_rx_data, 22'h100);

    // Push onto a full queue while popping, then drain
    @(negedge clk);
    pe_rx_ready = 1'b1;
    deliver(4'd7, ME, 8'd20, 22'h3FFFFF, 2'd3, 1'b1);
    @(negedge clk);
    rtr_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    pe_rx_ready = 1'b0;
    #1;
    chk("t5b_empty", pe_rx_valid, 0);
    chk("t5b_rx", rx_count, 6);
    chk("t5b_drop", drop_count, 3);
    chk("t5b_misroute_sticky", misroute, 1);

    // Reset mid-stall with traffic queued both ways
    @(negedge clk);
    rtr_full_in = 1'b1;
    send_tx(4'd2, 22'h55, 2'd1, 1'b0);
    deliver(4'd1, ME, 8'd2, 22'h66, 2'd2, 1'b0);
    @(negedge clk);
    send_tx(4'd0, 22'h77, 2'd0, 1'b0);
    deliver(4'd2, ME, 8'd4, 22'h88, 2'd3, 1'b0);
    @(negedge clk);
    pe_tx_valid = 1'b0; rtr_valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rtr_out", {rtr_valid_out, rtr_data_out}, 64'h0);
    chk("t6_rx_out", {pe_rx_valid, pe_rx_src, pe_rx_data, pe_rx_type, pe_rx_latency}, 64'h0);
    chk("t6_counts", {misroute, tx_count, rx_count, drop_count}, 64'h0);
    chk("t6_tx_ready", pe_tx_ready, 1);
    @(negedge clk);
    rst = 1'b0; rtr_full_in = 1'b0;
    send_tx(4'd5, 22'h15, 2'd1, 1'b1);
    @(negedge clk);
    pe_tx_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_pulse", rtr_valid_out, 1);
    chk("t6_ts_restart", rtr_data_out[31:24], 8'd1);
    chk("t6_tx_count", tx_count, 1);

    for (int i = 0; i < 20 && (exp_tx.size() != 0 || exp_rx.size() != 0); i++) @(negedge clk);
    chk("drain_tx", exp_tx.size(), 0);
    chk("drain_rx", exp_rx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
